// File: rtl/buttons_pkg.sv
// Shared constants for the Wishbone button peripheral: register word
// offsets and the bus address width.
package buttons_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] REG_LEVEL    = 3'd0;
    localparam logic [ADDR_W-1:0] REG_PRESSED  = 3'd1;
    localparam logic [ADDR_W-1:0] REG_RELEASED = 3'd2;
    localparam logic [ADDR_W-1:0] REG_IRQ_EN   = 3'd3;
    localparam logic [ADDR_W-1:0] REG_LONG     = 3'd4;

endpackage

// File: rtl/buttons_irq_if.sv
// Wishbone-style register bus used by the button peripheral.
//   cyc   : bus cycle/strobe (master -> slave)
//   we    : 1 = write         (master -> slave)
//   addr  : register word address
//   wdata : write data
//   rdata : read data, registered (slave -> master)
//   ack   : transfer acknowledge, registered (slave -> master)
interface buttons_irq_if;

    logic                          cyc;
    logic                          we;
    logic [buttons_pkg::ADDR_W-1:0] addr;
    logic [31:0]                   wdata;
    logic [31:0]                   rdata;
    logic                          ack;

    modport master (output cyc, output we, output addr, output wdata,
                    input  rdata, input ack);

    modport slave  (input  cyc, input we, input addr, input wdata,
                    output rdata, output ack);

endinterface

// File: rtl/buttons_debounce_ch.sv
// One button channel: optional polarity inversion, 2-flop synchroniser,
// debounce counter and stable level, plus single-cycle rise/fall pulses
// that coincide with the edge on which the stable level flips.
//   clk, reset_n : clock, async active-low reset
//   raw          : raw asynchronous pin
//   level        : debounced level, 1 = pressed
//   rise / fall  : combinational pulses, high on the flip cycle
module buttons_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pin;
    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // Inverting ahead of the synchroniser means an idle pin always syncs to 0,
    // so clearing the flops on reset is the idle state for either polarity.
    assign pin  = (ACTIVE_LOW != 0) ? ~raw : raw;

    // The counter only reaches CNT_LAST after that many consecutive mismatching
    // samples; any return to agreement clears it.
    assign flip = (sync2 != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise = flip & ~level;
    assign fall = flip &  level;

endmodule

// File: rtl/buttons_irq.sv
// Wishbone button peripheral: BTN_COUNT debounced inputs, latched
// press/release events (write-1-to-clear), per-channel interrupt enable and
// a registered level interrupt.
// Register map (word address): 0 LEVEL RO, 1 PRESSED W1C, 2 RELEASED W1C,
//   3 IRQ_EN RW, 4 LONG W1C, 5-7 read 0. Bits above BTN_COUNT read 0.
// Optional feature macro: BUTTONS_LONG_PRESS_EN enables the per-channel hold
//   counters and the LONG register; without it address 4 reads 0.
//   clk, reset_n : clock, async active-low reset
//   bus          : register bus, slave side
//   btn          : raw asynchronous button pins
//   irq          : level interrupt, registered
module buttons_irq
    import buttons_pkg::*;
#(
    parameter int BTN_COUNT         = 2,
    parameter int DEBOUNCE_CYCLES   = 65536,
    parameter int ACTIVE_LOW        = 0,
    parameter int LONG_PRESS_CYCLES = 2**24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    buttons_irq_if.slave         bus,
    input  logic [BTN_COUNT-1:0] btn,
    output logic                 irq
);

    logic [BTN_COUNT-1:0] level;
    logic [BTN_COUNT-1:0] rise;
    logic [BTN_COUNT-1:0] fall;
    logic [BTN_COUNT-1:0] pressed;
    logic [BTN_COUNT-1:0] released;
    logic [BTN_COUNT-1:0] irq_en;
    logic [BTN_COUNT-1:0] long_q;

    logic                 wr_en;
    logic [BTN_COUNT-1:0] wr_mask;
    logic [BTN_COUNT-1:0] clr_pressed;
    logic [BTN_COUNT-1:0] clr_released;
    logic [BTN_COUNT-1:0] clr_long;
    logic [31:0]          rd_val;

    // Write bits above the implemented channels have no home.
    logic                 unused_wdata;
    assign unused_wdata = ^bus.wdata[31:BTN_COUNT];

    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_ch
        buttons_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (btn[i]),
            .level   (level[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    // A write lands only on the edge that issues its ack.
    assign wr_en        = bus.cyc & bus.we & ~bus.ack;
    assign wr_mask      = bus.wdata[BTN_COUNT-1:0];
    assign clr_pressed  = (wr_en && bus.addr == REG_PRESSED)  ? wr_mask : '0;
    assign clr_released = (wr_en && bus.addr == REG_RELEASED) ? wr_mask : '0;
    assign clr_long     = (wr_en && bus.addr == REG_LONG)     ? wr_mask : '0;

`ifdef BUTTONS_LONG_PRESS_EN
    localparam int               HOLD_W   = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

    logic [BTN_COUNT-1:0] long_set;

    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_hold
        logic [HOLD_W-1:0] hold_cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                hold_cnt <= '0;
            end else if (!level[i]) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end

        // Fires only on the step into saturation, so one hold flags once.
        assign long_set[i] = level[i] && (hold_cnt == HOLD_MAX - HOLD_W'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            long_q <= '0;
        end else begin
            long_q <= (long_q & ~clr_long) | long_set;
        end
    end
`else
    logic unused_clr_long;
    assign unused_clr_long = |clr_long;
    assign long_q          = '0;
`endif

    // New events are OR-ed in after the clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pressed  <= '0;
            released <= '0;
            irq_en   <= '0;
            irq      <= 1'b0;
        end else begin
            pressed  <= (pressed  & ~clr_pressed)  | rise;
            released <= (released & ~clr_released) | fall;
            if (wr_en && bus.addr == REG_IRQ_EN) begin
                irq_en <= wr_mask;
            end
            irq <= |((pressed | released | long_q) & irq_en);
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            REG_LEVEL:    rd_val[BTN_COUNT-1:0] = level;
            REG_PRESSED:  rd_val[BTN_COUNT-1:0] = pressed;
            REG_RELEASED: rd_val[BTN_COUNT-1:0] = released;
            REG_IRQ_EN:   rd_val[BTN_COUNT-1:0] = irq_en;
            REG_LONG:     rd_val[BTN_COUNT-1:0] = long_q;
            default:      rd_val = '0;
        endcase
    end

    // ack toggles while cyc is held, so acks are never back-to-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ack   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ack   <= bus.cyc & ~bus.ack;
            bus.rdata <= (bus.cyc & ~bus.we) ? rd_val : 32'h0;
        end
    end

endmodule

// File: tb/tb_buttons_irq.sv
// Self-checking bench for buttons_irq (BTN_COUNT=4, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=32, ACTIVE_LOW=0). Define BUTTONS_LONG_PRESS_EN to
// exercise the long-press register as well.
module tb_buttons_irq;
    import buttons_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] btn;
    logic       irq;

    buttons_irq_if bus ();

    buttons_irq #(
        .BTN_COUNT         (4),
        .DEBOUNCE_CYCLES   (4),
        .ACTIVE_LOW        (0),
        .LONG_PRESS_CYCLES (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .btn     (btn),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input string tag);
        @(negedge clk);
        bus.cyc = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.ack) break;
        end
        chk({tag, "_ack"}, 32'(bus.ack), 32'h1);
        @(negedge clk);
        bus.cyc = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        sb.push_back(exp);
        @(negedge clk);
        bus.cyc = 1'b1; bus.we = 1'b0; bus.addr = a;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.ack) break;
        end
        chk({tag, "_ack"}, 32'(bus.ack), 32'h1);
        chk(tag, bus.rdata, sb.pop_front());
        @(negedge clk);
        bus.cyc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        btn       = '0;
        bus.cyc   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        idle(3);
        reset_n = 1'b1;

        // Build up state, then reset in the middle of a read.
        bus_write(REG_IRQ_EN, 32'hF, "pre_en");
        @(negedge clk); btn[0] = 1'b1;
        idle(10);
        chk("pre_irq", 32'(irq), 32'h1);
        @(negedge clk);
        bus.cyc = 1'b1; bus.we = 1'b0; bus.addr = REG_PRESSED;
        @(posedge clk); #1;
        chk("pre_rst_ack", 32'(bus.ack), 32'h1);
        #2;
        reset_n = 1'b0;
        btn     = '0;
        #1;
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        @(negedge clk); bus.cyc = 1'b0;
        idle(2);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) bus_read(3'(a), 32'h0, "rst_reg");

        // Clean press on btn[2] with cyc held: LEVEL flips 6 edges after the
        // pin, visible in rdata one edge later; ack alternates 1,0,1,0.
        for (int k = 1; k <= 8; k++) sb.push_back((k >= 7) ? 32'h4 : 32'h0);
        @(negedge clk);
        bus.cyc = 1'b1; bus.we = 1'b0; bus.addr = REG_LEVEL; btn[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk("lvl_timing", bus.rdata, sb.pop_front());
            chk("b2b_ack", 32'(bus.ack), 32'(k % 2));
        end
        @(negedge clk); bus.cyc = 1'b0;
        bus_read(REG_PRESSED,  32'h4, "press_evt");
        bus_read(REG_RELEASED, 32'h0, "press_norel");

        // 3-cycle glitch on btn[1] is rejected.
        @(negedge clk); btn[1] = 1'b1;
        idle(3);
        btn[1] = 1'b0;
        idle(8);
        bus_read(REG_LEVEL,   32'h4, "glitch_lvl");
        bus_read(REG_PRESSED, 32'h4, "glitch_prs");

        // Release, clear, then interrupt path.
        @(negedge clk); btn[2] = 1'b0;
        idle(8);
        bus_read(REG_RELEASED, 32'h4, "rel_evt");
        bus_write(REG_PRESSED,  32'h4, "clr_p");
        bus_write(REG_RELEASED, 32'h4, "clr_r");
        bus_read(REG_PRESSED,  32'h0, "clr_p_rd");
        bus_read(REG_RELEASED, 32'h0, "clr_r_rd");
        bus_write(REG_IRQ_EN, 32'h4, "en4");
        bus_read(REG_IRQ_EN, 32'h4, "en4_rd");
        chk("irq_idle", 32'(irq), 32'h0);
        @(negedge clk); btn[2] = 1'b1;
        idle(8);
        chk("irq_press", 32'(irq), 32'h1);
        bus_write(REG_PRESSED, 32'h4, "w1c_irq");
        chk("irq_hold", 32'(irq), 32'h1);
        @(posedge clk); #1;
        chk("irq_clr", 32'(irq), 32'h0);
        @(negedge clk); btn[2] = 1'b0;
        idle(8);
        chk("irq_rel", 32'(irq), 32'h1);
        bus_read(REG_RELEASED, 32'h4, "rel_evt2");
        bus_write(REG_RELEASED, 32'h4, "clr_r2");
        bus_write(REG_IRQ_EN, 32'h0, "en0");

        // W1C of PRESSED[0] on the very edge btn[0] flips: set wins.
        @(negedge clk); btn[0] = 1'b1;
        repeat (5) @(negedge clk);
        bus.cyc = 1'b1; bus.we = 1'b1; bus.addr = REG_PRESSED; bus.wdata = 32'h1;
        @(posedge clk); #1;
        chk("race_ack", 32'(bus.ack), 32'h1);
        @(negedge clk); bus.cyc = 1'b0; bus.we = 1'b0;
        bus_read(REG_PRESSED, 32'h1, "set_wins");
        bus_write(REG_PRESSED, 32'h1, "clr_p0");
        bus_read(REG_PRESSED, 32'h0, "clr_p0_rd");

        // Unmapped addresses, read-only LEVEL, upper bits ignored.
        bus_read(3'd5, 32'h0, "addr5");
        bus_read(3'd6, 32'h0, "addr6");
        bus_read(3'd7, 32'h0, "addr7");
        bus_write(REG_LEVEL, 32'h0, "wr_lvl");
        bus_read(REG_LEVEL, 32'h1, "lvl_ro");
        bus_write(REG_IRQ_EN, 32'hFFFF_FFFF, "en_all");
        bus_read(REG_IRQ_EN, 32'hF, "en_mask");
        bus_write(REG_IRQ_EN, 32'h0, "en_off");

        // Long press on btn[3].
        @(negedge clk); btn[0] = 1'b0;
        idle(8);
        bus_write(REG_LONG, 32'hF, "clr_long");
        @(negedge clk); btn[3] = 1'b1;
        idle(45);
        bus_read(REG_LEVEL, 32'h8, "long_lvl");
`ifdef BUTTONS_LONG_PRESS_EN
        bus_read(REG_LONG, 32'h8, "long_set");
        bus_write(REG_LONG, 32'h8, "long_w1c");
        idle(20);
        bus_read(REG_LONG, 32'h0, "long_once");
`else
        bus_read(REG_LONG, 32'h0, "long_absent");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
